// File: rtl/alu_arbiter.sv
// Round-robin arbiter/sequencer sharing one combinational ALU between R requesters.
// Each operation walks IDLE (accept) -> EXEC (capture ALU result) -> RESP (return to owner).
module alu_arbiter #(
    parameter int N = 8,
    parameter int R = 4,
    localparam int W = (R > 1) ? $clog2(R) : 1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [R-1:0]     req_valid,
    output logic [R-1:0]     req_ready,
    input  logic [R*N-1:0]   req_a,
    input  logic [R*N-1:0]   req_b,
    input  logic [R*3-1:0]   req_op,
    output logic [R-1:0]     rsp_valid,
    input  logic [R-1:0]     rsp_ready,
    output logic [N-1:0]     rsp_y,
    output logic             rsp_carry,
    output logic             rsp_zero,
    output logic             rsp_err,
    output logic [W-1:0]     rsp_id,
    output logic [N-1:0]     alu_a,
    output logic [N-1:0]     alu_b,
    output logic [2:0]       alu_op,
    input  logic [N-1:0]     alu_y,
    input  logic             alu_carry,
    input  logic             alu_zero
);

    typedef enum logic [1:0] {IDLE, EXEC, RESP} state_t;

    state_t         state_reg;
    logic [W-1:0]   ptr_reg;
    logic [W-1:0]   owner_reg;
    logic [N-1:0]   a_reg;
    logic [N-1:0]   b_reg;
    logic [2:0]     op_reg;
    logic [N-1:0]   y_reg;
    logic           carry_reg;
    logic           zero_reg;
    logic           err_reg;

    logic [N-1:0]   a_arr   [R];
    logic [N-1:0]   b_arr   [R];
    logic [2:0]     op_arr  [R];
    logic [W:0]     sum_arr [R];
    logic [W-1:0]   cand    [R];
    logic           found;
    logic [W-1:0]   winner;
    logic [W-1:0]   ptr_next;

    // cand[k] is the requester index k places after ptr, wrapped modulo R.
    for (genvar gi = 0; gi < R; gi++) begin : g_req
        assign a_arr[gi]   = req_a[gi*N +: N];
        assign b_arr[gi]   = req_b[gi*N +: N];
        assign op_arr[gi]  = req_op[gi*3 +: 3];
        assign sum_arr[gi] = {1'b0, ptr_reg} + (W+1)'(gi);
        assign cand[gi]    = (sum_arr[gi] >= (W+1)'(R)) ? W'(sum_arr[gi] - (W+1)'(R))
                                                        : sum_arr[gi][W-1:0];
        assign req_ready[gi] = rst_n && (state_reg == IDLE) && found && (winner == W'(gi));
        assign rsp_valid[gi] = (state_reg == RESP) && (owner_reg == W'(gi));
    end

    // Scan from the far end so the candidate closest to ptr is the last one written.
    always_comb begin
        found  = 1'b0;
        winner = '0;
        for (int k = R - 1; k >= 0; k--) begin
            if (req_valid[cand[k]]) begin
                found  = 1'b1;
                winner = cand[k];
            end
        end
    end

    assign ptr_next = (owner_reg == W'(R - 1)) ? '0 : owner_reg + W'(1);

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_reg <= IDLE;
            ptr_reg   <= '0;
            owner_reg <= '0;
            a_reg     <= '0;
            b_reg     <= '0;
            op_reg    <= '0;
            y_reg     <= '0;
            carry_reg <= 1'b0;
            zero_reg  <= 1'b0;
            err_reg   <= 1'b0;
        end else begin
            case (state_reg)
                IDLE: begin
                    if (found) begin
                        a_reg     <= a_arr[winner];
                        b_reg     <= b_arr[winner];
                        op_reg    <= op_arr[winner];
                        owner_reg <= winner;
                        state_reg <= EXEC;
                    end
                end
                EXEC: begin
                    if (op_reg[2:1] == 2'b11) begin
                        y_reg     <= '0;
                        carry_reg <= 1'b0;
                        zero_reg  <= 1'b1;
                        err_reg   <= 1'b1;
                    end else begin
                        y_reg     <= alu_y;
                        carry_reg <= alu_carry;
                        zero_reg  <= alu_zero;
                        err_reg   <= 1'b0;
                    end
                    state_reg <= RESP;
                end
                RESP: begin
                    if (rsp_ready[owner_reg]) begin
                        ptr_reg   <= ptr_next;
                        state_reg <= IDLE;
                    end
                end
                default: state_reg <= IDLE;
            endcase
        end
    end

    assign alu_a     = a_reg;
    assign alu_b     = b_reg;
    assign alu_op    = op_reg;
    assign rsp_y     = y_reg;
    assign rsp_carry = carry_reg;
    assign rsp_zero  = zero_reg;
    assign rsp_err   = err_reg;
    assign rsp_id    = owner_reg;

endmodule

// File: doc/alu_arbiter.md
# alu_arbiter

Round-robin arbiter and sequencer that shares one combinational N-bit ALU between R requesters. Each requester issues {a, b, op} through a valid/ready handshake. The block registers the operands, drives the shared ALU for one cycle, and captures the result. It then returns y/carry/zero to the owning requester through a per-requester valid/ready response. It sits between the requester pipelines and the single ALU instance, and is the only driver of the ALU's a/b/op inputs.

## Interface
- N, 8, datapath width; must match the shared ALU.
- R, 4, number of requesters; R ≥ 2. Requester index width is W = clog2(R).
- clk  in  1  clock; all state changes on its rising edge.
- rst_n  in  1  reset; synchronous, active-low.
- req_valid  in  R  bit i: requester i presents an operation.
- req_ready  out  R  bit i: request i is accepted this cycle; at most one bit is high.
- req_a  in  R*N  operand a of requester i, in bits [i*N +: N].
- req_b  in  R*N  operand b of requester i, in bits [i*N +: N].
- req_op  in  R*3  opcode of requester i, in bits [i*3 +: 3]. Encoding: 000 ADD, 001 SUB, 010 AND, 011 OR, 100 XOR, 101 SLT (signed).
- rsp_valid  out  R  bit i: response for requester i is valid; at most one bit is high.
- rsp_ready  in  R  bit i: requester i accepts its response.
- rsp_y  out  N  result (shared bus).
- rsp_carry  out  1  carry out; for SUB this is the raw carry of a + ~b + 1.
- rsp_zero  out  1  result equals zero.
- rsp_err  out  1  the opcode was 110 or 111 (illegal).
- rsp_id  out  W  index of the owning requester.
- alu_a  out  N  operand a to the shared ALU.
- alu_b  out  N  operand b to the shared ALU.
- alu_op  out  3  opcode to the shared ALU.
- alu_y  in  N  result from the shared ALU.
- alu_carry  in  1  carry from the shared ALU.
- alu_zero  in  1  zero flag from the shared ALU.

## Operation
- **FSM states.** IDLE, EXEC, RESP. Reset state is IDLE.
- **IDLE.**
  - If no req_valid bit is set, stay in IDLE.
  - Otherwise the winner is the first set bit found searching from index ptr upward, wrapping modulo R.
  - req_ready[winner] = 1 combinationally, only in IDLE. All other req_ready bits are 0.
  - On that cycle, capture req_a/req_b/req_op of the winner into the operand registers, set owner = winner, and go to EXEC.
- **EXEC.** alu_a/alu_b/alu_op already hold the operand registers. Capture alu_y/alu_carry/alu_zero into the result registers, then go to RESP.
  - Illegal op: result registers capture y = 0, carry = 0, zero = 1, err = 1. For legal ops err = 0.
- **RESP.**
  - rsp_valid[owner] = 1; rsp_id = owner.
  - rsp_y/rsp_carry/rsp_zero/rsp_err are driven from the result registers and held stable until the handshake.
  - When rsp_ready[owner] = 1: set ptr = (owner + 1) mod R and go to IDLE.
  - rsp_ready bits of non-owners are ignored.
- **ALU drive.** alu_a/alu_b/alu_op are driven from the operand registers in every state. They change only on a request handshake.
- **Round-robin pointer.** ptr advances only on response completion, never on acceptance alone. A requester that has just completed has lowest priority in the next arbitration.
- **Request side while busy.** req_ready stays 0 in EXEC and RESP. A requester holding req_valid keeps its request pending with no loss.

## Timing
- **Reset values.** All of the following are 0 while rst_n = 0 at a clock edge:
  - FSM, ptr, owner, operand registers, result registers;
  - hence req_ready, rsp_valid, rsp_y, rsp_carry, rsp_zero, rsp_err, rsp_id, alu_a, alu_b, alu_op.
  - Reset mid-operation (EXEC or RESP) drops the transaction; no response is issued after reset.
- **Latency.** Request handshake at edge t, EXEC during cycle t+1, rsp_valid high from cycle t+2.
- **Throughput.** Minimum 3 cycles per operation: IDLE, EXEC, RESP with rsp_ready already high.
- **Back-to-back.** The response handshake and the next request acceptance never occur in the same cycle. The next acceptance is one cycle later, in IDLE.
- **Response stall.** rsp_valid and the response data hold indefinitely while rsp_ready[owner] = 0.
- **Request stability.** req_* of non-winners may change at any time. The winner's values are sampled only on its handshake cycle.
- **Width rules.** All results are N bits. The arbiter performs no arithmetic on data; the only arithmetic is the wrap of ptr modulo R, including non-power-of-two R.

## Test plan
- **Reset.** Hold rst_n = 0 for 2 cycles with all req_valid = 1 → all outputs 0 and req_ready = 0. After release, req_ready = 0001 in the first cycle.
- **Single request, N=8.** Requester 2 issues ADD a=0xF0, b=0x20 → rsp_valid = 0100 two cycles after acceptance, rsp_y = 0x10, rsp_carry = 1, rsp_zero = 0, rsp_id = 2, rsp_err = 0.
- **Fairness.** All four requesters hold req_valid with rsp_ready = 1 → grant order 0, 1, 2, 3, 0. Each operation takes exactly 3 cycles.
- **Wrap and pointer.** ptr = 3 (after requester 2 completes); requesters 1 and 3 valid → requester 3 is granted first, then requester 1.
- **Response backpressure and SLT.** Requester 1 issues SLT a=0x80, b=0x01; hold rsp_ready low for 5 cycles → rsp_y = 0x01 held stable throughout. Requester 0 asserts req_valid during the stall → req_ready stays 0 until IDLE.
- **Illegal op and mid-op reset.** op = 111 → rsp_y = 0, rsp_zero = 1, rsp_err = 1. A separate ADD reset during EXEC → no rsp_valid afterwards; ptr = 0.
